// File: rtl/code_serializer.sv
// code_serializer
// Parallel-to-serial front end for the serial code-lock checker.
// A WIDTH-bit word is taken over a valid/ready handshake and sent on x as
// one frame: a sync cycle (x=0, frame=1), then WIDTH data bits MSB first,
// then GAP_CYCLES idle cycles before the next word can be accepted.
//
// Optional feature macro: SER_PARITY_EN
//   When defined, an even-parity bit (XOR of all data bits) is sent after
//   the last data bit, with frame=1, and done moves onto that parity cycle.
//   When undefined, there is no parity cycle.
//
// in_ready is combinational. x, frame and done are registered, so each one
// shows the value for the state that the FSM has just entered.

module code_serializer #(
    parameter int WIDTH      = 4,   // code word width, legal 2..16
    parameter int GAP_CYCLES = 2    // idle cycles after each frame, 0 is legal
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             frame,
    output logic             done
);

    // Bit counter holds 0..WIDTH: the number of data bits already driven.
    localparam int CW = $clog2(WIDTH + 1);
    // The gap counter counts 0..GAP_CYCLES-1. It stays one bit wide for tiny gaps.
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_ALL_SENT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST     = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_GAP    = 3'd4
    } state_e;

    // With no gap configured, the frame goes straight back to IDLE.
    localparam state_e POST_FRAME = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [GW-1:0]    gap_q,   gap_d;
    logic             x_q,     x_d;
    logic             frame_q, frame_d;
    logic             done_q,  done_d;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // The block can accept only from IDLE, and never while reset is asserted.
    assign in_ready = (state_q == S_IDLE) && !rst;

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        // NOTE: Every signal written here gets a default first. Any path that leaves one unassigned would infer a latch.
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        x_d      = 1'b0;
        frame_d  = 1'b0;
        done_d   = 1'b0;
`ifdef SER_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    // Accept edge. Capture the word. The sync cycle drives x=0 with frame=1.
                    state_d  = S_SYNC;
                    shift_d  = in_data;
                    cnt_d    = '0;
                    frame_d  = 1'b1;
`ifdef SER_PARITY_EN
                    parity_d = ^in_data;
`endif
                end
            end

            S_SYNC: begin
                // Enter DATA and drive the MSB out.
                state_d = S_DATA;
                x_d     = shift_q[WIDTH-1];
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = CW'(1);
                frame_d = 1'b1;
            end

            S_DATA: begin
                if (cnt_q == CNT_ALL_SENT) begin
`ifdef SER_PARITY_EN
                    // The parity bit follows the data and carries the done pulse.
                    state_d = S_PARITY;
                    x_d     = parity_q;
                    frame_d = 1'b1;
                    done_d  = 1'b1;
`else
                    state_d = POST_FRAME;
                    gap_d   = '0;
`endif
                end else begin
                    x_d     = shift_q[WIDTH-1];
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q + CW'(1);
                    frame_d = 1'b1;
`ifndef SER_PARITY_EN
                    // done goes high with the final data bit.
                    done_d  = (cnt_q == CNT_LAST_BIT);
`endif
                end
            end

`ifdef SER_PARITY_EN
            S_PARITY: begin
                state_d = POST_FRAME;
                gap_d   = '0;
            end
`endif

            S_GAP: begin
                // Hold x=0 and frame=0 for GAP_CYCLES cycles, then reopen the handshake.
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers. Synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: Sequential state uses non-blocking assignments only. Every register then samples its pre-edge value.
        if (rst) begin
            // NOTE: The shift register and counters are cleared as well. A truncated frame then leaves no stale word behind.
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            x_q      <= 1'b0;
            frame_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            x_q      <= x_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
`ifdef SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign x     = x_q;
    assign frame = frame_q;
    assign done  = done_q;

endmodule

// File: tb/tb_code_serializer.sv
// tb_code_serializer
// Directed bench for code_serializer with WIDTH=4 and GAP_CYCLES=2.
// Every observation packs {x, frame, done, in_ready}, sampled 1 time unit
// after the rising edge. It is compared with hand-computed vectors.
// Optional feature macro: SER_PARITY_EN selects the parity-frame scenario.

module tb_code_serializer;

    localparam int WIDTH = 4;
    localparam int GAP   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             x;
    logic             frame;
    logic             done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    code_serializer #(
        .WIDTH      (WIDTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .frame    (frame),
        .done     (done)
    );

    // Advance past the next rising edge and leave time for the outputs to settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({x, frame, done, in_ready} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: x/frame/done/ready=%b expected 0000",
                         i, {x, frame, done, in_ready});
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({x, frame, done, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release: x/frame/done/ready=%b expected 0001",
                     {x, frame, done, in_ready});
        end
        step();
        checks++;
        if ({x, frame, done, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_idle: x/frame/done/ready=%b expected 0001",
                     {x, frame, done, in_ready});
        end
    endtask

`ifndef SER_PARITY_EN
    // Word 1001 is accepted at edge N. Entry i is sampled after edge N+i.
    task automatic test_basic_frame();
        logic [3:0] exp_v [8];
        exp_v = '{4'b0100, 4'b1100, 4'b0100, 4'b0100,
                  4'b1110, 4'b0000, 4'b0000, 4'b0001};
        in_data  = 4'b1001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = 4'b0000;   // a change after the accept edge must not matter
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            checks++;
            if ({x, frame, done, in_ready} !== exp_v[i]) begin
                errors++;
                $display("FAIL basic_frame N+%0d: x/frame/done/ready=%b expected %b",
                         i, {x, frame, done, in_ready}, exp_v[i]);
            end
        end
    endtask

    // in_valid stays high. 1001 goes first, then 0110 is presented right after.
    // The second accept lands WIDTH+2+GAP = 8 edges after the first.
    task automatic test_back_to_back();
        logic [3:0] exp_v [16];
        exp_v = '{4'b0100, 4'b1100, 4'b0100, 4'b0100,
                  4'b1110, 4'b0000, 4'b0000, 4'b0001,
                  4'b0100, 4'b0100, 4'b1100, 4'b1100,
                  4'b0110, 4'b0000, 4'b0000, 4'b0001};
        in_data  = 4'b1001;
        in_valid = 1'b1;
        step();
        in_data  = 4'b0110;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            if (i == 8) begin
                in_valid = 1'b0;
                in_data  = 4'b0000;
            end
            checks++;
            if ({x, frame, done, in_ready} !== exp_v[i]) begin
                errors++;
                $display("FAIL back_to_back N+%0d: x/frame/done/ready=%b expected %b",
                         i, {x, frame, done, in_ready}, exp_v[i]);
            end
        end
    endtask

    // A one-cycle in_valid pulse of 1111 during DATA must be ignored.
    task automatic test_ignored_request();
        logic [3:0] exp_v [9];
        exp_v = '{4'b0100, 4'b1100, 4'b0100, 4'b0100,
                  4'b1110, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
        in_data  = 4'b1001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) step();
            if (i == 2) begin
                in_valid = 1'b0;
                in_data  = 4'b0000;
            end
            checks++;
            if ({x, frame, done, in_ready} !== exp_v[i]) begin
                errors++;
                $display("FAIL ignored_request N+%0d: x/frame/done/ready=%b expected %b",
                         i, {x, frame, done, in_ready}, exp_v[i]);
            end
            if (i == 1) begin
                in_valid = 1'b1;
                in_data  = 4'b1111;
            end
        end
    endtask

    // rst is raised during the 2nd data bit. The next edge truncates the frame.
    task automatic test_reset_mid_frame();
        logic [3:0] exp_v [3];
        exp_v = '{4'b0100, 4'b1100, 4'b0100};
        in_data  = 4'b1001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            checks++;
            if ({x, frame, done, in_ready} !== exp_v[i]) begin
                errors++;
                $display("FAIL reset_mid_pre N+%0d: x/frame/done/ready=%b expected %b",
                         i, {x, frame, done, in_ready}, exp_v[i]);
            end
        end
        rst = 1'b1;
        step();
        checks++;
        if ({x, frame, done, in_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_edge: x/frame/done/ready=%b expected 0000",
                     {x, frame, done, in_ready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({x, frame, done, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_release: x/frame/done/ready=%b expected 0001",
                     {x, frame, done, in_ready});
        end
        // The edge where the 4th bit would have carried done: nothing must appear.
        step();
        checks++;
        if ({x, frame, done, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_no_done: x/frame/done/ready=%b expected 0001",
                     {x, frame, done, in_ready});
        end
        // A fresh word after the truncation must serialize normally.
        test_basic_frame();
    endtask
`else
    // Word 1011 is followed by parity 1^0^1^1 = 1, and done sits on the parity cycle.
    task automatic test_parity();
        logic [3:0] exp_v [9];
        exp_v = '{4'b0100, 4'b1100, 4'b0100, 4'b1100, 4'b1100,
                  4'b1110, 4'b0000, 4'b0000, 4'b0001};
        in_data  = 4'b1011;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = 4'b0000;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) step();
            checks++;
            if ({x, frame, done, in_ready} !== exp_v[i]) begin
                errors++;
                $display("FAIL parity_frame N+%0d: x/frame/done/ready=%b expected %b",
                         i, {x, frame, done, in_ready}, exp_v[i]);
            end
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
`ifndef SER_PARITY_EN
        test_basic_frame();
        test_back_to_back();
        test_ignored_request();
        test_reset_mid_frame();
`else
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
